approx_avg_window: RTL and testbench

//  Parametrised sliding-window approximate-average filter; successor to the fixed 9-tap, 8-bit filter.

---
 rtl/approx_avg_window.sv | 115 +++++++++++
 tb/tb_approx_avg_window.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/approx_avg_window.sv
// Sliding-window approximate-average filter with a 2-stage pipeline.
// Optional synchronous window clear is enabled by defining AVG_WINDOW_CLR_EN.
module approx_avg_window #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 9,
    parameter  int SHIFT = 3,
    localparam int SW    = DW + $clog2(DEPTH + 1),
    localparam int YW    = DW + $clog2(2 * DEPTH) - SHIFT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] X,
`ifdef AVG_WINDOW_CLR_EN
    input  logic          clr,
`endif
    output logic          out_valid,
    output logic [YW-1:0] Y
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          clr_now;
`ifdef AVG_WINDOW_CLR_EN
    assign clr_now = clr;
`else
    assign clr_now = 1'b0;
`endif

    logic [DW-1:0]    win_p0 [DEPTH];
    logic [SW-1:0]    sum_p0;
    logic [CW-1:0]    fill_p0;

    logic [DW-1:0]    win_nx [DEPTH];
    logic [SW-1:0]    sum_nx;
    logic [CW-1:0]    fill_nx;
    logic [SW-1:0]    avg_nx;
    logic [DEPTH-1:0] flags_nx;

    logic [DEPTH-1:0] flags_p1;
    logic             vld_p1;

    logic [DW-1:0]    x_appr;
    logic [SW:0]      acc_p2;

    // Keeps the low YW bits of the scaled accumulator.
    function automatic logic [YW-1:0] scale_out(input logic [SW:0] acc);
        logic [SW:0] shifted;
        shifted = acc >> SHIFT;
        return shifted[YW-1:0];
    endfunction

    // Stage 0 -> 1: next window, running sum, fill count and flags against the new average
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            win_nx[i] = clr_now ? '0 : win_p0[i];
        end
        sum_nx  = clr_now ? '0 : sum_p0;
        fill_nx = clr_now ? '0 : fill_p0;
        if (in_valid) begin
            sum_nx = sum_nx - {{(SW-DW){1'b0}}, win_nx[DEPTH-1]} + {{(SW-DW){1'b0}}, X};
            for (int i = DEPTH - 1; i > 0; i--) begin
                win_nx[i] = win_nx[i-1];
            end
            win_nx[0] = X;
            if (fill_nx != CW'(DEPTH)) begin
                fill_nx = fill_nx + CW'(1);
            end
        end
        avg_nx = sum_nx / SW'(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            flags_nx[i] = {{(SW-DW){1'b0}}, win_nx[i]} > avg_nx;
        end
    end

    // Stage 1 -> 2: largest unflagged sample, then sum + DEPTH*x_appr
    always_comb begin
        x_appr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!flags_p1[i] && (win_p0[i] > x_appr)) begin
                x_appr = win_p0[i];
            end
        end
        acc_p2 = {1'b0, sum_p0} + ((SW+1)'(DEPTH) * {{(SW+1-DW){1'b0}}, x_appr});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_p0[i] <= '0;
            end
            sum_p0    <= '0;
            fill_p0   <= '0;
            flags_p1  <= '0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            Y         <= '0;
        end else begin
            if (in_valid || clr_now) begin
                win_p0  <= win_nx;
                sum_p0  <= sum_nx;
                fill_p0 <= fill_nx;
            end
            if (in_valid) begin
                flags_p1 <= flags_nx;
            end
            vld_p1    <= in_valid && (fill_nx == CW'(DEPTH));
            out_valid <= vld_p1;
            if (vld_p1) begin
                Y <= scale_out(acc_p2);
            end
        end
    end

endmodule

// File: tb/tb_approx_avg_window.sv
// Randomised and directed bench for approx_avg_window against a queue-based model.
module tb_approx_avg_window;

    localparam int DW    = 8;
    localparam int DEPTH = 9;
    localparam int SHIFT = 3;
    localparam int YW    = DW + $clog2(2 * DEPTH) - SHIFT;
`ifdef AVG_WINDOW_CLR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] X;
`ifdef AVG_WINDOW_CLR_EN
    logic          clr;
`endif
    logic          out_valid;
    logic [YW-1:0] Y;

    int n_checks = 0;
    int n_fail   = 0;

    int q[$];
    bit pend_v;
    int pend_y;
    bit exp_ov;
    int exp_y;

    approx_avg_window #(.DW(DW), .DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .X        (X),
`ifdef AVG_WINDOW_CLR_EN
        .clr      (clr),
`endif
        .out_valid(out_valid),
        .Y        (Y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_result();
        int sum, avg, xa;
        sum = 0;
        foreach (q[i]) sum += q[i];
        avg = sum / DEPTH;
        xa = 0;
        foreach (q[i]) if (q[i] <= avg && q[i] > xa) xa = q[i];
        return ((sum + DEPTH * xa) >> SHIFT) & ((1 << YW) - 1);
    endfunction

    task automatic model_edge(input bit v, input int x, input bit r, input bit c);
        if (r) begin
            q.delete();
            pend_v = 1'b0;
            exp_ov = 1'b0;
            exp_y  = 0;
        end else begin
            exp_ov = pend_v;
            if (pend_v) exp_y = pend_y;
            if (c && CLR_EN) q.delete();
            pend_v = 1'b0;
            if (v) begin
                q.push_back(x);
                if (q.size() > DEPTH) void'(q.pop_front());
                if (q.size() == DEPTH) begin
                    pend_v = 1'b1;
                    pend_y = model_result();
                end
            end
        end
    endtask

    task automatic step(input bit v, input int x, input bit r, input bit c, input string tag);
        in_valid = v;
        X        = DW'(x);
        reset    = r;
`ifdef AVG_WINDOW_CLR_EN
        clr      = c;
`endif
        @(posedge clk);
        model_edge(v, x, r, c);
        #1;
        check({tag, "_ov"}, int'(out_valid), int'(exp_ov));
        check({tag, "_y"}, int'(Y), exp_y);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        X        = '0;
`ifdef AVG_WINDOW_CLR_EN
        clr      = 1'b0;
`endif
        step(0, 0, 1, 0, "rst");
        step(0, 0, 1, 0, "rst");
        check("rst_ov_const", int'(out_valid), 0);
        check("rst_y_const", int'(Y), 0);

        // Ramp fill and first results
        for (int i = 1; i <= 9; i++) step(1, i, 0, 0, "t1_fill");
        step(1, 10, 0, 0, "t1");
        check("t1_ov_const", int'(out_valid), 1);
        check("t1_y_const", int'(Y), 11);
        step(0, 0, 0, 0, "t2");
        check("t2_y_const", int'(Y), 13);

        // Full-scale window
        for (int i = 0; i < 9; i++) step(1, 255, 0, 0, "t3_fill");
        step(0, 0, 0, 0, "t3");
        check("t3_y_const", int'(Y), 573);

        // Outlier excluded from x_appr, then idle gap holds Y
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, "t4_fill");
        step(1, 90, 0, 0, "t4_last");
        step(0, 0, 0, 0, "t4");
        check("t4_y_const", int'(Y), 11);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "t4_idle");
        check("t4_hold_ov_const", int'(out_valid), 0);
        check("t4_hold_y_const", int'(Y), 11);

        // Mid-stream reset
        for (int i = 0; i < 5; i++) step(1, 50 + i, 0, 0, "t5_pre");
        step(0, 0, 1, 0, "t5_rst");
        for (int i = 0; i < 9; i++) step(1, 8, 0, 0, "t5_fill");
        step(0, 0, 0, 0, "t5");
        check("t5_y_const", int'(Y), 18);

`ifdef AVG_WINDOW_CLR_EN
        // Clear together with an accept
        step(0, 0, 1, 0, "t6_rst");
        for (int i = 1; i <= 9; i++) step(1, i, 0, 0, "t6_fill");
        step(1, 7, 0, 1, "t6_clr");
        check("t6_y_const", int'(Y), 11);
        check("t6_ov_const", int'(out_valid), 1);
        for (int i = 0; i < 8; i++) step(1, 20, 0, 0, "t6_refill");
        step(0, 0, 0, 0, "t6_after");
        check("t6_after_ov_const", int'(out_valid), 1);
`endif

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bit v, r, c;
            int x;
            v = ($urandom_range(0, 99) < 75);
            r = ($urandom_range(0, 99) < 2);
            c = CLR_EN && ($urandom_range(0, 99) < 3);
            x = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            step(v, x, r, c, "rand");
        end
        step(0, 0, 0, 0, "drain");
        step(0, 0, 0, 0, "drain");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
